// File: rtl/bram_stream_fifo_ctrl_if.sv
// Stream and BRAM-port bundle for the BRAM-backed streaming FIFO controller.
// The master modport is the controller's view; slave is the surrounding logic's view.
interface bram_stream_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_W     = 9
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [ADDR_W-1:0]     ram_addra;
  logic [DATA_WIDTH-1:0] ram_dina;
  logic                  ram_wren;
  logic [ADDR_W-1:0]     ram_addrb;
  logic                  ram_rden;
  logic [DATA_WIDTH-1:0] ram_doutb;
  logic [ADDR_W+1:0]     level;

  modport master (
    input  s_data, s_valid, m_ready, ram_doutb,
    output s_ready, m_data, m_valid, ram_addra, ram_dina, ram_wren, ram_addrb, ram_rden, level
  );

  modport slave (
    output s_data, s_valid, m_ready, ram_doutb,
    input  s_ready, m_data, m_valid, ram_addra, ram_dina, ram_wren, ram_addrb, ram_rden, level
  );
endinterface

// File: rtl/bram_stream_fifo_ctrl.sv
// Valid/ready FIFO controller around a simple dual-port BRAM with a 1-cycle registered read,
// using a 2-entry output buffer to absorb the read latency.
module bram_stream_fifo_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  bram_stream_fifo_ctrl_if.master bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int LVL_W  = ADDR_W + 2;

  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [PTR_W-1:0]      ram_occ;
  logic                  inflight_reg;
  logic [1:0]            ob_cnt_reg;
  logic                  ob_head_reg;
  logic                  ob_tail;
  logic [DATA_WIDTH-1:0] ob_reg [2];
  logic [LVL_W-1:0]      level_reg;
  logic [LVL_W-1:0]      level_next;
  logic                  full;
  logic                  wren;
  logic                  rden;
  logic                  pop;
  logic [2:0]            credit;

  always_comb begin
    ram_occ    = wr_ptr_reg - rd_ptr_reg;
    full       = (ram_occ == PTR_W'(DEPTH));
    // Reset blocks BRAM traffic so memory contents survive a reset untouched
    wren       = bus.s_valid && !full && !rst;
    pop        = (ob_cnt_reg != 2'd0) && bus.m_ready;
    // Occupancy of buffer after this edge; a read may only issue if it leaves room
    credit     = 3'(ob_cnt_reg) + 3'(inflight_reg) - 3'(pop);
    rden       = (ram_occ != '0) && (credit < 3'd2) && !rst;
    ob_tail    = ob_head_reg ^ ob_cnt_reg[0];
    level_next = level_reg + LVL_W'(wren) - LVL_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      inflight_reg <= 1'b0;
      ob_cnt_reg   <= 2'd0;
      ob_head_reg  <= 1'b0;
      level_reg    <= '0;
    end else begin
      if (wren) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rden) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      inflight_reg <= rden;
      ob_cnt_reg   <= credit[1:0];
      if (pop) ob_head_reg <= ~ob_head_reg;
      level_reg    <= level_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ob
      always_ff @(posedge clk) begin
        if (inflight_reg && (ob_tail == 1'(gi))) ob_reg[gi] <= bus.ram_doutb;
      end
    end
  endgenerate

  assign bus.s_ready   = !full;
  assign bus.m_valid   = (ob_cnt_reg != 2'd0);
  assign bus.m_data    = ob_reg[ob_head_reg];
  assign bus.ram_addra = wr_ptr_reg[ADDR_W-1:0];
  assign bus.ram_dina  = bus.s_data;
  assign bus.ram_wren  = wren;
  assign bus.ram_addrb = rd_ptr_reg[ADDR_W-1:0];
  assign bus.ram_rden  = rden;
  assign bus.level     = level_reg;
endmodule

// File: tb/tb_bram_stream_fifo_ctrl.sv
// Self-checking bench: per-cycle vector table after reset, then streaming, fill, random and
// reset-in-flight sequences checked against a queue scoreboard and a behavioural BRAM.
module tb_bram_stream_fifo_ctrl;
  localparam int DW    = 64;
  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   data_ctr;
  logic [DW-1:0] sb [$];
  logic [DW-1:0] mem [DEPTH];

  bram_stream_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

  bram_stream_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural simple dual-port BRAM with registered read
  always @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_addra] <= bus.ram_dina;
    if (bus.ram_rden) bus.ram_doutb <= mem[bus.ram_addrb];
  end

  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          mr;
    logic          e_sr;
    logic          e_wren;
    logic          e_rden;
    logic          e_mv;
    logic [DW-1:0] e_md;
    int            e_lvl;
    int            e_aa;
    int            e_ab;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drives n_new fresh words while draining everything already queued plus those words
  task automatic stream_run(input int n_new, input int sv_pct, input int mr_pct,
                            input bit nogap, input int max_cyc, input string tag);
    int sent, got, target, cyc, first_pop;
    bit stall_prev, started;
    logic [DW-1:0] prev_data;
    sent = 0; got = 0; cyc = 0; first_pop = -1;
    stall_prev = 1'b0; started = 1'b0; prev_data = '0;
    target = sb.size() + n_new;
    while (got < target && cyc < max_cyc) begin
      @(negedge clk);
      bus.s_valid = (sent < n_new) && ($urandom_range(99) < sv_pct);
      bus.s_data  = DW'(data_ctr);
      bus.m_ready = ($urandom_range(99) < mr_pct);
      #1;
      chk({tag, "_level"}, DW'(bus.level), DW'(sb.size()));
      if (stall_prev) begin
        chk({tag, "_stall_valid"}, DW'(bus.m_valid), DW'(1));
        chk({tag, "_stall_data"}, bus.m_data, prev_data);
      end
      if (nogap && bus.s_valid) chk({tag, "_s_ready"}, DW'(bus.s_ready), DW'(1));
      if (nogap && started) chk({tag, "_nogap"}, DW'(bus.m_valid), DW'(1));
      if (bus.s_valid && bus.s_ready) begin
        sb.push_back(bus.s_data);
        data_ctr++;
        sent++;
      end
      if (bus.m_valid && bus.m_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s_dup actual=%0h required=none", tag, bus.m_data);
        end else begin
          chk({tag, "_data"}, bus.m_data, sb.pop_front());
        end
        got++;
        if (!started) first_pop = cyc;
        started = 1'b1;
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      cyc++;
    end
    chk({tag, "_words_out"}, DW'(got), DW'(target));
    if (nogap) chk({tag, "_first_out_cycle"}, DW'(first_pop), DW'(3));
    $display("%s: sent %0d received %0d in %0d cycles", tag, sent, got, cyc);
  endtask

  initial begin
    int accepted;
    bit ok;
    checks = 0; errors = 0; data_ctr = 0;
    rst = 1'b1;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;

    vecs[0]  = '{1'b1, 64'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0,  0, 0, 0};
    vecs[1]  = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0,  1, 0, 0};
    vecs[2]  = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,  1, 0, 0};
    vecs[3]  = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'hA5, 1, 0, 0};
    vecs[4]  = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,  0, 0, 0};
    vecs[5]  = '{1'b1, 64'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0,  0, 1, 0};
    vecs[6]  = '{1'b1, 64'h22, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,  1, 2, 1};
    vecs[7]  = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0,  2, 0, 2};
    vecs[8]  = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h11, 2, 0, 0};
    vecs[9]  = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h11, 2, 0, 0};
    vecs[10] = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h11, 2, 0, 0};
    vecs[11] = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h22, 1, 0, 0};
    vecs[12] = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,  0, 0, 0};

    // Reset held for two edges
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_s_ready", DW'(bus.s_ready), DW'(1));
    chk("rst_m_valid", DW'(bus.m_valid), DW'(0));
    chk("rst_level", DW'(bus.level), DW'(0));
    chk("rst_wren", DW'(bus.ram_wren), DW'(0));
    chk("rst_rden", DW'(bus.ram_rden), DW'(0));
    $display("reset: s_ready=%0b m_valid=%0b level=%0d", bus.s_ready, bus.m_valid, bus.level);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      bus.s_valid = vecs[i].sv;
      bus.s_data  = vecs[i].sd;
      bus.m_ready = vecs[i].mr;
      #1;
      chk($sformatf("vec%0d_s_ready", i), DW'(bus.s_ready), DW'(vecs[i].e_sr));
      chk($sformatf("vec%0d_wren", i), DW'(bus.ram_wren), DW'(vecs[i].e_wren));
      chk($sformatf("vec%0d_rden", i), DW'(bus.ram_rden), DW'(vecs[i].e_rden));
      chk($sformatf("vec%0d_m_valid", i), DW'(bus.m_valid), DW'(vecs[i].e_mv));
      chk($sformatf("vec%0d_level", i), DW'(bus.level), DW'(vecs[i].e_lvl));
      if (vecs[i].e_mv) chk($sformatf("vec%0d_m_data", i), bus.m_data, vecs[i].e_md);
      if (vecs[i].e_wren) begin
        chk($sformatf("vec%0d_addra", i), DW'(bus.ram_addra), DW'(vecs[i].e_aa));
        chk($sformatf("vec%0d_dina", i), bus.ram_dina, vecs[i].sd);
      end
      if (vecs[i].e_rden) chk($sformatf("vec%0d_addrb", i), DW'(bus.ram_addrb), DW'(vecs[i].e_ab));
      $display("vec%0d: sv=%0b mr=%0b wren=%0b rden=%0b m_valid=%0b m_data=%0h level=%0d",
               i, bus.s_valid, bus.m_ready, bus.ram_wren, bus.ram_rden, bus.m_valid, bus.m_data, bus.level);
    end

    // Continuous stream at full rate
    data_ctr = 1000;
    stream_run(1000, 100, 100, 1'b1, 3000, "stream");

    // Fill to capacity with the sink stalled
    data_ctr = 5000;
    accepted = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      bus.s_valid = 1'b1; bus.m_ready = 1'b0; bus.s_data = DW'(data_ctr);
      #1;
      if (!bus.s_ready) break;
      sb.push_back(bus.s_data);
      data_ctr++;
      accepted++;
    end
    chk("fill_accepted", DW'(accepted), DW'(DEPTH + 2));
    chk("fill_level", DW'(bus.level), DW'(DEPTH + 2));
    $display("fill: accepted %0d level=%0d", accepted, bus.level);
    @(negedge clk);
    bus.s_valid = 1'b0; bus.m_ready = 1'b1;
    #1;
    chk("fill_pop_valid", DW'(bus.m_valid), DW'(1));
    chk("fill_pop_data", bus.m_data, sb.pop_front());
    ok = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.m_ready = 1'b0; bus.s_valid = 1'b1; bus.s_data = DW'(data_ctr);
      #1;
      if (bus.s_ready) begin
        sb.push_back(bus.s_data);
        data_ctr++;
        ok = 1'b1;
        break;
      end
    end
    chk("fill_reaccept", DW'(ok), DW'(1));
    stream_run(0, 0, 100, 1'b0, 2000, "drain");

    // Random valid/ready traffic
    data_ctr = 32'h0010_0000;
    stream_run(10000, 50, 30, 1'b0, 60000, "random");

    // Reset while a read is in flight and the buffer holds data
    data_ctr = 32'h100;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.s_valid = 1'b1; bus.m_ready = 1'b0; bus.s_data = DW'(data_ctr);
      data_ctr++;
    end
    repeat (4) begin
      @(negedge clk);
      bus.s_valid = 1'b0; bus.m_ready = 1'b0;
    end
    @(negedge clk);
    bus.m_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1; bus.m_ready = 1'b0; bus.s_valid = 1'b1; bus.s_data = 64'hDEAD;
    @(negedge clk);
    rst = 1'b0; bus.s_valid = 1'b0;
    #1;
    chk("midrst_m_valid", DW'(bus.m_valid), DW'(0));
    chk("midrst_level", DW'(bus.level), DW'(0));
    chk("midrst_s_ready", DW'(bus.s_ready), DW'(1));
    chk("midrst_rden", DW'(bus.ram_rden), DW'(0));
    $display("midrst: m_valid=%0b level=%0d", bus.m_valid, bus.level);
    sb.delete();
    data_ctr = 1;
    stream_run(1, 100, 100, 1'b0, 50, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
